run_tx: RTL and testbench

Serial run-length transmitter: the generating end of the x1 run-detector link. It accepts run-length symbols (0–3) over a valid/ready interface and buffers them in a small FIFO. Each symbol is serialized onto the single-bit line `x1` as L ones followed by one terminating zero. Alongside the stream it produces `y_exp`, the cycle-exact Y1 pulse the downstream detector must raise, so benches and on-chip checkers can compare directly.

---
 rtl/run_pkg.sv | 19 +
 rtl/sym_fifo.sv | 66 ++++++
 rtl/run_tx.sv | 141 ++++++++++++++
 tb/tb_run_tx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/run_pkg.sv
// run_pkg: shared definitions for the x1 run-length link. Both the run
// transmitter and the run detector import this package.
//   len_t    : 2-bit run-length symbol (0 = NULL, 1..3 = run of ones)
//   state_t  : transmitter serializer states
//   LEN_NULL : the NULL symbol value (one idle zero bit, no terminator)
package run_pkg;

    typedef logic [1:0] len_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ONES = 2'b01,
        TERM = 2'b10,
        GAPS = 2'b11
    } state_t;

    localparam len_t LEN_NULL = 2'd0;

endpackage

// File: rtl/sym_fifo.sv
// sym_fifo: DEPTH x 2-bit synchronous FIFO holding run-length symbols.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   push, din    : write request and data (ignored while full)
//   pop, dout    : read request (ignored while empty); dout shows the head
//   count        : current occupancy, 0..DEPTH
//   full, empty  : occupancy flags
// The head is read combinationally from storage, so a symbol written at
// one edge can only be popped at a later edge (there is no bypass path).
module sym_fifo
    import run_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  len_t                   din,
    input  logic                   pop,
    output len_t                   dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    len_t             mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push is refused while full even if a pop happens on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/run_tx.sv
// run_tx: serial run-length transmitter. Symbols arrive over valid/ready,
// are buffered in sym_fifo and serialized onto x1 as L ones followed by a
// terminating zero (NULL = a single idle zero). y_exp marks the cycle the
// downstream detector must pulse Y1, i.e. every run terminator.
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   in_valid, in_len    : symbol offer and its run length (0 = NULL)
//   in_ready            : FIFO not full
//   x1                  : registered serial bit stream
//   y_exp               : registered expected detector pulse
//   sym_start           : registered, first bit of every symbol
//   busy                : serializer active or symbols pending
//   state_tx            : serializer state (debug)
//   fifo_count          : FIFO occupancy
// All registered outputs describe the state the FSM was in during the
// previous cycle, so a symbol loaded at edge N shows its first bit after N+1.
module run_tx
    import run_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [1:0]             in_len,
    output logic                   in_ready,
    output logic                   x1,
    output logic                   y_exp,
    output logic                   sym_start,
    output logic                   busy,
    output logic [1:0]             state_tx,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam logic [2:0] GAP_N = 3'(GAP);

    state_t     state, state_n;
    logic [1:0] cnt, cnt_n;       // ones still to send
    logic [2:0] gcnt, gcnt_n;     // gap bits still to send
    logic       nul, nul_n;       // current symbol is NULL
    logic       first, first_n;   // next emitted bit is the symbol's first
    logic       x1_n, y_n, ss_n;
    logic       next_sym;
    logic       pop;
    len_t       head;
    logic       full, empty;

    sym_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .din   (in_len),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign in_ready = !full;
    assign busy     = (state != IDLE) || !empty;
    assign state_tx = state;
    assign pop      = next_sym && !empty;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        gcnt_n   = gcnt;
        nul_n    = nul;
        first_n  = first;
        x1_n     = 1'b0;
        y_n      = 1'b0;
        ss_n     = 1'b0;
        next_sym = 1'b0;
        case (state)
            IDLE: next_sym = 1'b1;
            ONES: begin
                x1_n    = 1'b1;
                ss_n    = first;
                first_n = 1'b0;
                if (cnt == 2'd1) state_n = TERM;
                else             cnt_n   = cnt - 2'd1;
            end
            TERM: begin
                y_n     = !nul;
                ss_n    = first;
                first_n = 1'b0;
                if (GAP > 0 && !nul) begin
                    state_n = GAPS;
                    gcnt_n  = GAP_N;
                end else begin
                    next_sym = 1'b1;
                end
            end
            GAPS: begin
                if (gcnt == 3'd1) next_sym = 1'b1;
                else              gcnt_n   = gcnt - 3'd1;
            end
        endcase
        // Loading straight from TERM/GAPS keeps the stream back-to-back.
        if (next_sym) begin
            if (empty) begin
                state_n = IDLE;
            end else begin
                first_n = 1'b1;
                if (head == LEN_NULL) begin
                    state_n = TERM;
                    nul_n   = 1'b1;
                end else begin
                    state_n = ONES;
                    cnt_n   = head;
                    nul_n   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            gcnt      <= '0;
            nul       <= 1'b0;
            first     <= 1'b0;
            x1        <= 1'b0;
            y_exp     <= 1'b0;
            sym_start <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            gcnt      <= gcnt_n;
            nul       <= nul_n;
            first     <= first_n;
            x1        <= x1_n;
            y_exp     <= y_n;
            sym_start <= ss_n;
        end
    end

endmodule

// File: tb/tb_run_tx.sv
// tb_run_tx: self-checking bench for run_tx. Two instances share clock and
// reset: index 0 runs with GAP=0, index 1 with GAP=2. A table of symbol
// sequences is replayed; each accepted symbol pushes its expected bits
// {x1, y_exp, sym_start} onto a scoreboard queue, popped one per cycle.
module tb_run_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid [2];
    logic [1:0] in_len [2];
    logic       in_ready [2];
    logic       x1 [2];
    logic       y_exp [2];
    logic       sym_start [2];
    logic       busy [2];
    logic [1:0] state_tx [2];
    logic [2:0] fifo_count [2];

    int n_chk  = 0;
    int n_fail = 0;

    logic [2:0] sb [$];

    always #5 clk = ~clk;

    run_tx #(.DEPTH(4), .GAP(0)) u_g0 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_len(in_len[0]),
        .in_ready(in_ready[0]), .x1(x1[0]), .y_exp(y_exp[0]),
        .sym_start(sym_start[0]), .busy(busy[0]), .state_tx(state_tx[0]),
        .fifo_count(fifo_count[0]));

    run_tx #(.DEPTH(4), .GAP(2)) u_g2 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_len(in_len[1]),
        .in_ready(in_ready[1]), .x1(x1[1]), .y_exp(y_exp[1]),
        .sym_start(sym_start[1]), .busy(busy[1]), .state_tx(state_tx[1]),
        .fifo_count(fifo_count[1]));

    typedef struct {
        int               g;      // 0: GAP=0 instance, 1: GAP=2 instance
        int               n;
        logic [0:5][1:0]  lens;
        int               ones;
        int               ys;
        int               sss;
        int               stall;
        int               maxc;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_model(input logic [1:0] l, input int gapv);
        for (int i = 0; i < int'(l); i++) sb.push_back({1'b1, 1'b0, i == 0});
        sb.push_back({1'b0, l != 2'd0, l == 2'd0});
        if (l != 2'd0) repeat (gapv) sb.push_back(3'b000);
    endtask

    task automatic run_vec(input vec_t v);
        int k = 0, idx = 0, trail = 0;
        int ones = 0, ys = 0, sss = 0, stall = 0, maxc = 0;
        int g = v.g;
        logic acc;
        logic [2:0] e, a;
        while (idx < v.n || sb.size() > 0 || trail < 3) begin
            acc = 1'b0;
            if (idx < v.n) begin
                in_valid[g] = 1'b1;
                in_len[g]   = v.lens[idx];
                if (in_ready[g]) begin
                    push_model(v.lens[idx], g ? 2 : 0);
                    acc = 1'b1;
                end else begin
                    stall++;
                end
            end else begin
                in_valid[g] = 1'b0;
            end
            @(posedge clk);
            if (acc) idx++;
            @(negedge clk);
            if (k >= 2 && sb.size() > 0) begin
                e = sb.pop_front();
            end else begin
                e = 3'b000;
                if (k >= 2 && idx >= v.n) trail++;
            end
            a = {x1[g], y_exp[g], sym_start[g]};
            chk("stream", 32'(a), 32'(e));
            ones += int'(x1[g]);
            ys   += int'(y_exp[g]);
            sss  += int'(sym_start[g]);
            if (int'(fifo_count[g]) > maxc) maxc = int'(fifo_count[g]);
            k++;
            if (k > 80) begin
                chk("timeout", 32'd1, 32'd0);
                break;
            end
        end
        in_valid[g] = 1'b0;
        sb.delete();
        chk("ones_total", ones, v.ones);
        chk("y_total", ys, v.ys);
        chk("start_total", sss, v.sss);
        chk("stalls", stall, v.stall);
        chk("max_count", maxc, v.maxc);
        chk("busy_after", 32'(busy[g]), 32'd0);
        chk("count_after", 32'(fifo_count[g]), 32'd0);
        chk("state_after", 32'(state_tx[g]), 32'd0);
    endtask

    initial begin
        vt[0] = '{0, 1, {2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 1, 1, 1, 0, 1};
        vt[1] = '{0, 3, {2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0}, 6, 3, 3, 0, 2};
        vt[2] = '{1, 2, {2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0}, 4, 2, 2, 0, 1};
        vt[3] = '{0, 3, {2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0}, 1, 1, 3, 0, 1};
        vt[4] = '{1, 2, {2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0}, 3, 1, 2, 0, 1};
        vt[5] = '{0, 3, {2'd2, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0}, 5, 2, 3, 0, 2};
        vt[6] = '{0, 6, {2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1}, 8, 6, 6, 1, 4};

        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0;
            in_len[i]   = 2'd0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_x1", 32'(x1[0]), 32'd0);
        chk("rst_y", 32'(y_exp[0]), 32'd0);
        chk("rst_start", 32'(sym_start[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_state", 32'(state_tx[0]), 32'd0);
        chk("rst_count", 32'(fifo_count[0]), 32'd0);
        chk("rst_ready", 32'(in_ready[0]), 32'd1);

        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // Reset during the second one of an L=3 symbol, with L=2 queued.
        in_valid[0] = 1'b1; in_len[0] = 2'd3;
        @(posedge clk); @(negedge clk);          // after e0
        in_len[0] = 2'd2;
        @(posedge clk); @(negedge clk);          // after e1
        in_valid[0] = 1'b0;
        @(posedge clk); @(negedge clk);          // after e2: first one
        chk("pre_rst_one1", 32'(x1[0]), 32'd1);
        @(posedge clk); @(negedge clk);          // after e3: second one
        chk("pre_rst_one2", 32'(x1[0]), 32'd1);
        chk("pre_rst_count", 32'(fifo_count[0]), 32'd1);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);          // after e4
        reset = 1'b0;
        chk("mid_rst_x1", 32'(x1[0]), 32'd0);
        chk("mid_rst_y", 32'(y_exp[0]), 32'd0);
        chk("mid_rst_count", 32'(fifo_count[0]), 32'd0);
        chk("mid_rst_state", 32'(state_tx[0]), 32'd0);
        chk("mid_rst_busy", 32'(busy[0]), 32'd0);
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            chk("post_rst_line", 32'({x1[0], y_exp[0]}), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
